// File: rtl/pc_seq_pkg.sv
// Shared definitions for the ECC-core program sequencer: state encoding,
// opcode values, instruction field positions and run-status codes.
package pc_seq_pkg;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_CLR  = 5'b00010,
        S_RUN  = 5'b00100,
        S_LOOP = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_ABORT = 2'b01,
        ST_WRAP  = 2'b10,
        ST_NONE  = 2'b11
    } status_t;

    localparam logic [3:0] OP_LOOP = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_W   = 4;
    localparam int CNT_LSB = 4;
    localparam int CNT_W   = 8;
    localparam int BODY_W  = 3;
    localparam int TMR_W   = 11;

    // Loop length in cycles; 255*8 fits in 11 bits without truncation.
    function automatic logic [TMR_W-1:0] loop_ticks(input logic [CNT_W-1:0] count,
                                                    input logic [BODY_W-1:0] body);
        return TMR_W'(count) * (TMR_W'(body) + TMR_W'(1));
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Host command, ROM snoop and PC-counter control bundle for pc_seq_ctrl.
interface pc_seq_ctrl_if #(parameter int INSTR_W = 16);
    logic               start;
    logic               abort;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [7:0]         pc_addr;
    logic               pc_rst_n;
    logic               pc_enable;
    logic               loop_enable;
    logic [7:0]         cnt1;
    logic [3:0]         cnt2;
    logic               busy;
    logic               done;
    logic [1:0]         status;
    logic [15:0]        cycles;

    modport master (
        output start, abort, instr, instr_valid, pc_addr,
        input  pc_rst_n, pc_enable, loop_enable, cnt1, cnt2, busy, done, status, cycles
    );

    modport slave (
        input  start, abort, instr, instr_valid, pc_addr,
        output pc_rst_n, pc_enable, loop_enable, cnt1, cnt2, busy, done, status, cycles
    );
endinterface

// File: rtl/pc_loop_timer.sv
// Load/decrement timer measuring how long the sequencer stays in a loop body.
module pc_loop_timer import pc_seq_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] value,
    output logic             zero
);
    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (dec && cnt != '0)
            cnt <= cnt - TMR_W'(1);
    end

    // Marks the decrement that lands on zero, i.e. the last body cycle.
    assign zero = dec && (cnt == TMR_W'(1));
endmodule

// File: rtl/pc_seq_ctrl.sv
// Program sequencer: starts/stops the PC counter, turns LOOP words into
// loop-load strobes and ends the run on HALT, abort or address wrap.
module pc_seq_ctrl import pc_seq_pkg::*; #(
    parameter int INSTR_W = 16
) (
    input logic          clk,
    input logic          rst,
    pc_seq_ctrl_if.slave bus
);
    state_t           state, state_nx;
    logic             pc_rst_n_q, pc_rst_n_nx;
    logic             pc_enable_q, pc_enable_nx;
    logic             loop_enable_q, loop_enable_nx;
    logic [7:0]       cnt1_q, cnt1_nx;
    logic [3:0]       cnt2_q, cnt2_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    status_t          status_q, status_nx;
    logic [15:0]      cycles_q, cycles_nx;

    logic [OPC_W-1:0] opcode;
    logic [CNT_W-1:0] count;
    logic [BODY_W-1:0] body;
    logic [TMR_W-1:0] ticks;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic             is_halt, is_loop, wrap, finish;
    status_t          fin_code;
    logic             unused_shift_msb;

    assign opcode  = bus.instr[INSTR_W-1 -: OPC_W];
    assign count   = bus.instr[CNT_LSB +: CNT_W];
    assign body    = bus.instr[BODY_W-1:0];
    assign unused_shift_msb = bus.instr[BODY_W];
    assign ticks   = loop_ticks(count, body);
    assign is_halt = bus.instr_valid && opcode == OP_HALT;
    assign is_loop = bus.instr_valid && opcode == OP_LOOP && count != '0;
    assign wrap    = pc_enable_q && bus.pc_addr == 8'hFF;

    pc_loop_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .value (ticks),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            pc_rst_n_q    <= 1'b0;
            pc_enable_q   <= 1'b0;
            loop_enable_q <= 1'b0;
            cnt1_q        <= '0;
            cnt2_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            status_q      <= ST_NONE;
            cycles_q      <= '0;
        end else begin
            state         <= state_nx;
            pc_rst_n_q    <= pc_rst_n_nx;
            pc_enable_q   <= pc_enable_nx;
            loop_enable_q <= loop_enable_nx;
            cnt1_q        <= cnt1_nx;
            cnt2_q        <= cnt2_nx;
            busy_q        <= busy_nx;
            done_q        <= done_nx;
            status_q      <= status_nx;
            cycles_q      <= cycles_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        pc_rst_n_nx    = pc_rst_n_q;
        pc_enable_nx   = pc_enable_q;
        loop_enable_nx = 1'b0;
        cnt1_nx        = cnt1_q;
        cnt2_nx        = cnt2_q;
        busy_nx        = busy_q;
        done_nx        = 1'b0;
        status_nx      = status_q;
        cycles_nx      = (busy_q && cycles_q != 16'hFFFF) ? cycles_q + 16'd1 : cycles_q;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        finish         = 1'b0;
        fin_code       = ST_NONE;

        // Abort outranks HALT and wrap; wrap outranks a LOOP word.
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_nx    = S_CLR;
                    pc_rst_n_nx = 1'b0;
                    busy_nx     = 1'b1;
                    status_nx   = ST_NONE;
                    cycles_nx   = '0;
                end
            end
            S_CLR: begin
                if (bus.abort) begin
                    finish   = 1'b1;
                    fin_code = ST_ABORT;
                end else begin
                    state_nx     = S_RUN;
                    pc_rst_n_nx  = 1'b1;
                    pc_enable_nx = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    finish   = 1'b1;
                    fin_code = ST_ABORT;
                end else if (is_halt) begin
                    finish   = 1'b1;
                    fin_code = ST_HALT;
                end else if (wrap) begin
                    finish   = 1'b1;
                    fin_code = ST_WRAP;
                end else if (is_loop) begin
                    state_nx       = S_LOOP;
                    loop_enable_nx = 1'b1;
                    cnt1_nx        = count;
                    cnt2_nx        = {1'b0, body};
                    tmr_load       = 1'b1;
                end
            end
            S_LOOP: begin
                tmr_dec = 1'b1;
                if (bus.abort) begin
                    finish   = 1'b1;
                    fin_code = ST_ABORT;
                end else if (wrap) begin
                    finish   = 1'b1;
                    fin_code = ST_WRAP;
                end else if (tmr_zero) begin
                    state_nx = S_RUN;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (finish) begin
            state_nx     = S_DONE;
            pc_enable_nx = 1'b0;
            busy_nx      = 1'b0;
            done_nx      = 1'b1;
            status_nx    = fin_code;
        end
    end

    assign bus.pc_rst_n    = pc_rst_n_q;
    assign bus.pc_enable   = pc_enable_q;
    assign bus.loop_enable = loop_enable_q;
    assign bus.cnt1        = cnt1_q;
    assign bus.cnt2        = cnt2_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.status      = status_q;
    assign bus.cycles      = cycles_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: PC counter + ROM environment, a per-cycle reference
// model of the sequencer rules, and directed programs with literal expectations.
module tb_pc_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_seq_ctrl_if #(.INSTR_W(16)) bus ();
    pc_seq_ctrl #(.INSTR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int le_cnt = 0;

    // PC counter and synchronous ROM the sequencer normally sits in front of.
    logic [15:0] rom [256];
    logic [7:0]  pc = 8'd0;
    logic [15:0] rom_q = 16'd0;
    logic        rom_v = 1'b0;
    always @(posedge clk) begin
        if (!bus.pc_rst_n) pc <= 8'd0;
        else if (bus.pc_enable) pc <= pc + 8'd1;
        rom_q <= rom[pc];
        rom_v <= bus.pc_rst_n && bus.pc_enable;
    end
    assign bus.pc_addr     = pc;
    assign bus.instr       = rom_q;
    assign bus.instr_valid = rom_v;

    // Reference model: phase 0 idle, 1 clear, 2 run, 3 loop body, 4 done.
    int          m_ph = 0;
    int          m_left = 0;
    logic        e_rstn = 0, e_en = 0, e_le = 0, e_busy = 0, e_done = 0;
    logic [7:0]  e_c1 = 0;
    logic [3:0]  e_c2 = 0;
    logic [1:0]  e_st = 2'b11;
    int          e_cyc = 0;

    always @(posedge clk) begin : model
        logic [3:0] op;
        logic [7:0] cnt;
        logic [2:0] sh;
        bit         fin, wrap;
        logic [1:0] code;
        op   = bus.instr[15:12];
        cnt  = bus.instr[11:4];
        sh   = bus.instr[2:0];
        fin  = 0;
        code = 2'b11;
        wrap = e_en && bus.pc_addr == 8'hFF;
        if (!rst) begin
            m_ph = 0; m_left = 0; e_rstn = 0; e_en = 0; e_le = 0; e_c1 = 0; e_c2 = 0;
            e_busy = 0; e_done = 0; e_st = 2'b11; e_cyc = 0;
        end else begin
            e_done = 0;
            e_le   = 0;
            if (e_busy && e_cyc < 65535) e_cyc++;
            case (m_ph)
                0, 4: if (bus.start) begin
                    m_ph = 1; e_rstn = 0; e_busy = 1; e_st = 2'b11; e_cyc = 0;
                end
                1: if (bus.abort) begin fin = 1; code = 2'b01; end
                   else begin m_ph = 2; e_rstn = 1; e_en = 1; end
                2: begin
                    if (bus.abort) begin fin = 1; code = 2'b01; end
                    else if (bus.instr_valid && op == 4'hF) begin fin = 1; code = 2'b00; end
                    else if (wrap) begin fin = 1; code = 2'b10; end
                    else if (bus.instr_valid && op == 4'hE && cnt != 0) begin
                        m_ph = 3; e_le = 1; e_c1 = cnt; e_c2 = {1'b0, sh};
                        m_left = int'(cnt) * (int'(sh) + 1);
                    end
                end
                3: begin
                    m_left--;
                    if (bus.abort) begin fin = 1; code = 2'b01; end
                    else if (wrap) begin fin = 1; code = 2'b10; end
                    else if (m_left == 0) m_ph = 2;
                end
                default: ;
            endcase
            if (fin) begin m_ph = 4; e_en = 0; e_busy = 0; e_done = 1; e_st = code; end
        end
    end

    always @(negedge clk) begin
        if (bus.loop_enable) le_cnt++;
        if (chk_en) begin
            n_chk++;
            if ({bus.pc_rst_n, bus.pc_enable, bus.loop_enable, bus.busy, bus.done, bus.status,
                 bus.cnt1, bus.cnt2, bus.cycles} !==
                {e_rstn, e_en, e_le, e_busy, e_done, e_st, e_c1, e_c2, e_cyc[15:0]}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got rstn=%b en=%b le=%b busy=%b done=%b st=%b c1=%0d c2=%0d cyc=%0d, want rstn=%b en=%b le=%b busy=%b done=%b st=%b c1=%0d c2=%0d cyc=%0d",
                         $time, bus.pc_rst_n, bus.pc_enable, bus.loop_enable, bus.busy, bus.done,
                         bus.status, bus.cnt1, bus.cnt2, bus.cycles, e_rstn, e_en, e_le, e_busy,
                         e_done, e_st, e_c1, e_c2, e_cyc);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 256; i++) rom[i] = w;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // sel 0 waits for done, sel 1 for loop_enable; n = negedges waited.
    task automatic wait_sig(input int sel, input int max, input string nm, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < max) begin
            @(negedge clk);
            n++;
            hit = (sel == 0) ? bus.done : bus.loop_enable;
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no event in %0d cycles, want one", nm, max);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst = 1'b0;
        fill_rom(16'h0000);
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_pc_rst_n", int'(bus.pc_rst_n), 0);
        chk("reset_status", int'(bus.status), 3);
        chk("reset_busy", int'(bus.busy), 0);
        rst = 1'b1;
        @(negedge clk);

        // NOP, NOP, HALT; start pulse during RUN must be ignored.
        rom[2] = 16'hF000;
        pulse_start();
        chk("t1_clr_pc_rst_n", int'(bus.pc_rst_n), 0);
        chk("t1_clr_busy", int'(bus.busy), 1);
        @(negedge clk);
        chk("t1_run_pc_rst_n", int'(bus.pc_rst_n), 1);
        chk("t1_run_pc_enable", int'(bus.pc_enable), 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_sig(0, 50, "t1_done", n);
        chk("t1_done_delay", n, 3);
        chk("t1_status", int'(bus.status), 0);
        chk("t1_busy_falls", int'(bus.busy), 0);
        chk("t1_cycles", int'(bus.cycles), 5);
        repeat (2) @(negedge clk);

        // LOOP 3x(2+1) with an inner LOOP and HALTs inside the body.
        fill_rom(16'hF000);
        rom[0] = 16'h0000; rom[1] = 16'hE032; rom[3] = 16'hE0FF;
        base = le_cnt;
        pulse_start();
        wait_sig(1, 50, "t2_strobe", n);
        chk("t2_strobe_delay", n, 4);
        chk("t2_cnt1", int'(bus.cnt1), 3);
        chk("t2_cnt2", int'(bus.cnt2), 2);
        wait_sig(0, 50, "t2_done", n);
        chk("t2_loop_len", n, 10);
        chk("t2_status", int'(bus.status), 0);
        chk("t2_cycles", int'(bus.cycles), 14);
        chk("t2_strobe_count", le_cnt - base, 1);
        repeat (2) @(negedge clk);

        // Zero-count LOOP is a NOP.
        fill_rom(16'h0000);
        rom[1] = 16'hE005; rom[3] = 16'hF000;
        base = le_cnt;
        pulse_start();
        wait_sig(0, 50, "t3_done", n);
        chk("t3_done_delay", n, 6);
        chk("t3_cycles", int'(bus.cycles), 6);
        chk("t3_no_strobe", le_cnt - base, 0);
        repeat (2) @(negedge clk);

        // Shift 13 uses only its low three bits: cnt2=5, body 6 cycles.
        fill_rom(16'hF000);
        rom[0] = 16'h0000; rom[1] = 16'hE01D;
        pulse_start();
        wait_sig(1, 50, "t4_strobe", n);
        chk("t4_cnt1", int'(bus.cnt1), 1);
        chk("t4_cnt2", int'(bus.cnt2), 5);
        wait_sig(0, 50, "t4_done", n);
        chk("t4_loop_len", n, 7);
        chk("t4_cycles", int'(bus.cycles), 11);
        repeat (2) @(negedge clk);

        // No HALT anywhere: run ends on address wrap.
        fill_rom(16'h0000);
        pulse_start();
        wait_sig(0, 400, "t5_done", n);
        chk("t5_done_delay", n, 257);
        chk("t5_status", int'(bus.status), 2);
        chk("t5_cycles", int'(bus.cycles), 257);
        repeat (2) @(negedge clk);

        // Abort inside the loop body, same cycle a HALT word arrives.
        fill_rom(16'hF000);
        rom[0] = 16'h0000; rom[1] = 16'hE032;
        pulse_start();
        wait_sig(1, 50, "t6_strobe", n);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t6_done", int'(bus.done), 1);
        chk("t6_status", int'(bus.status), 1);
        chk("t6_pc_enable", int'(bus.pc_enable), 0);
        chk("t6_cycles", int'(bus.cycles), 5);
        repeat (2) @(negedge clk);
        chk("t6_done_single", int'(bus.done), 0);

        // Reset in the middle of a run.
        fill_rom(16'h0000);
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t7_pc_rst_n", int'(bus.pc_rst_n), 0);
        chk("t7_pc_enable", int'(bus.pc_enable), 0);
        chk("t7_busy", int'(bus.busy), 0);
        chk("t7_status", int'(bus.status), 3);
        chk("t7_cycles", int'(bus.cycles), 0);
        chk("t7_cnt1", int'(bus.cnt1), 0);
        repeat (4) @(negedge clk);
        chk("t7_no_done", int'(bus.done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
